// File: rtl/hdc_pkg.sv
// Shared hypervector defaults, beat-count helper and the result_box FSM encoding.
package hdc_pkg;
  localparam int unsigned DIM_DEF   = 1023;
  localparam int unsigned OUT_W_DEF = 64;

  typedef enum logic [1:0] {IDLE, SEND, TERM} box_state_t;

  function automatic int unsigned beats(input int unsigned dim, input int unsigned out_w);
    return (dim + 1) / out_w;
  endfunction
endpackage

// File: rtl/vec_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on dout_o while non-empty.
module vec_fifo #(
  parameter  int unsigned W     = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          wr_i,
  input  logic [W-1:0]  din_i,
  input  logic          rd_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   cnt_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, rp_q;

  // Extra pointer bit separates full from empty when indices coincide.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr_i) wp_q <= wp_q + 1'b1;
      if (rd_i) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wp_q[AW-1:0]] <= din_i;
  end

  assign cnt_o   = wp_q - rp_q;
  assign full_o  = (cnt_o == (AW+1)'(DEPTH));
  assign empty_o = (cnt_o == '0);
  assign dout_o  = mem_q[rp_q[AW-1:0]];
endmodule

// File: rtl/result_box.sv
// Buffers core result vectors and streams them out LSB beat first, then a terminator beat.
// Define RESULT_BOX_STATS_EN to enable the accepted-vector counter on vec_count.
module result_box import hdc_pkg::*; #(
  parameter int unsigned DIM   = DIM_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             store,
  input  logic [DIM:0]     core_result,
  input  logic             last,
  output logic [OUT_W-1:0] out_d,
  output logic             out_v,
  input  logic             out_r,
  output logic             out_last,
  output logic             overflow,
  output logic [31:0]      vec_count
);
  localparam int unsigned BEATS = beats(DIM, OUT_W);
  localparam int unsigned KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned AW    = $clog2(DEPTH);

  box_state_t                  state_q;
  logic [KW-1:0]               k_q;
  logic                        last_pend_q, overflow_q;
  logic [DIM:0]                head;
  logic [BEATS-1:0][OUT_W-1:0] head_beats;
  logic                        full, empty, pop, push, drop, last_beat;
  logic [AW:0]                 cnt;

  assign head_beats = head;
  assign last_beat  = (k_q == KW'(BEATS-1));
  assign pop        = run & (state_q == SEND) & out_r & last_beat;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign push       = run & store & (~full | pop);
  assign drop       = run & store & full & ~pop;

  vec_fifo #(.W(DIM+1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (~run),
    .wr_i    (push),
    .din_i   (core_result),
    .rd_i    (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      state_q     <= IDLE;
      k_q         <= '0;
      last_pend_q <= 1'b0;
    end else begin
      if (last) last_pend_q <= 1'b1;
      case (state_q)
        // Entering SEND on the push edge gives beat 0 the cycle after the store.
        IDLE: begin
          if (!empty)           state_q <= SEND;
          else if (last_pend_q) state_q <= TERM;
          else if (push)        state_q <= SEND;
        end
        SEND: begin
          if (out_r) begin
            if (last_beat) begin
              k_q <= '0;
              if (cnt > (AW+1)'(1) || push) state_q <= SEND;
              else if (last_pend_q)         state_q <= TERM;
              else                          state_q <= IDLE;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        TERM: begin
          if (out_r) begin
            state_q     <= IDLE;
            last_pend_q <= last;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

`ifdef RESULT_BOX_STATS_EN
  logic [31:0] vec_count_q;
  always_ff @(posedge clk) begin
    if (rst)       vec_count_q <= '0;
    else if (push) vec_count_q <= vec_count_q + 32'd1;
  end
  assign vec_count = vec_count_q;
`else
  assign vec_count = '0;
`endif

  assign overflow = overflow_q;
  assign out_v    = (state_q != IDLE);
  assign out_last = (state_q == TERM);
  assign out_d    = (state_q == SEND) ? head_beats[k_q] : '0;
endmodule

// File: tb/tb_result_box.sv
// Directed bench for result_box with default parameters (16 beats of 64 bits, 4-deep FIFO).
module tb_result_box;
  logic         clk = 1'b0;
  logic         rst, run, store, last, out_r;
  logic [1023:0] core_result;
  logic [63:0]  out_d;
  logic         out_v, out_last, overflow;
  logic [31:0]  vec_count;

  int n_cmp = 0;
  int n_err = 0;
  int acc   = 0;

  result_box #(.DIM(1023), .OUT_W(64), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .run(run), .store(store), .core_result(core_result),
    .last(last), .out_d(out_d), .out_v(out_v), .out_r(out_r),
    .out_last(out_last), .overflow(overflow), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run, store, last, rdy;
    int          base;
    logic        ev;
    logic [63:0] ed;
    logic        el;
  } vec_t;
  vec_t tbl[10];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [1023:0] mkvec(input int base);
    logic [1023:0] v;
    for (int i = 0; i < 16; i++) v[i*64 +: 64] = 64'(base + i);
    return v;
  endfunction

  function automatic logic [31:0] expcnt(input int a);
`ifdef RESULT_BOX_STATS_EN
    return 32'(a);
`else
    return 32'(a) & 32'd0;
`endif
  endfunction

  initial begin
    // run, store, last, rdy, base, exp_v, exp_d, exp_last (expected before the edge)
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0,      1'b0, 64'h0,  1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,      1'b0, 64'h0,  1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,      1'b1, 64'h0,  1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 0,      1'b1, 64'h0,  1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 0,      1'b0, 64'h0,  1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 'h50,   1'b0, 64'h0,  1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,      1'b1, 64'h50, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,      1'b1, 64'h50, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,      1'b0, 64'h0,  1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,      1'b0, 64'h0,  1'b0};

    rst = 1'b1; run = 1'b0; store = 1'b0; last = 1'b0; out_r = 1'b0;
    core_result = '0;
    tick(); tick();
    rst = 1'b0; run = 1'b1;
    chk("reset out_v", 64'(out_v), 64'd0);
    chk("reset out_d", out_d, 64'd0);
    chk("reset out_last", 64'(out_last), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset vec_count", 64'(vec_count), 64'(expcnt(0)));

    // Single vector, consecutive beats from t+1
    out_r = 1'b1; store = 1'b1; core_result = mkvec(0); acc++;
    tick();
    store = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("single out_v", 64'(out_v), 64'd1);
      chk("single out_d", out_d, 64'(k));
      tick();
    end
    chk("single idle", 64'(out_v), 64'd0);

    // Terminator alone, hold, store then run drop
    for (int i = 0; i < 10; i++) begin
      run = tbl[i].run; store = tbl[i].store; last = tbl[i].last; out_r = tbl[i].rdy;
      core_result = mkvec(tbl[i].base);
      if (tbl[i].store) acc++;
      chk("tbl out_v", 64'(out_v), 64'(tbl[i].ev));
      chk("tbl out_d", out_d, tbl[i].ed);
      chk("tbl out_last", 64'(out_last), 64'(tbl[i].el));
      tick();
    end
    run = 1'b1; store = 1'b0; last = 1'b0;

    // Backpressure: ready toggles, each beat held then taken once
    store = 1'b1; core_result = mkvec('h100); acc++;
    tick();
    store = 1'b0;
    for (int c = 0; c < 32; c++) begin
      out_r = (c % 2 == 1);
      chk("bp out_v", 64'(out_v), 64'd1);
      chk("bp out_d", out_d, 64'('h100 + c / 2));
      tick();
    end
    chk("bp idle", 64'(out_v), 64'd0);

    // Overflow: six stores into 4-deep FIFO with no drain
    chk("pre ovf", 64'(overflow), 64'd0);
    out_r = 1'b0;
    for (int j = 0; j < 6; j++) begin
      store = 1'b1; core_result = mkvec(j * 16);
      if (j < 4) acc++;
      tick();
    end
    store = 1'b0;
    chk("ovf flag", 64'(overflow), 64'd1);
    chk("ovf vec_count", 64'(vec_count), 64'(expcnt(acc)));
    out_r = 1'b1;
    for (int n = 0; n < 64; n++) begin
      chk("ovf out_v", 64'(out_v), 64'd1);
      chk("ovf out_d", out_d, 64'(n));
      tick();
    end
    chk("ovf idle", 64'(out_v), 64'd0);

    // Run dropped during beat 5
    store = 1'b1; core_result = mkvec('h200); acc++;
    tick();
    store = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("drop out_d", out_d, 64'('h200 + k));
      tick();
    end
    chk("drop beat5", out_d, 64'h205);
    run = 1'b0;
    tick();
    run = 1'b1;
    chk("drop out_v", 64'(out_v), 64'd0);
    chk("drop overflow", 64'(overflow), 64'd1);
    chk("drop vec_count", 64'(vec_count), 64'(expcnt(acc)));
    tick();
    chk("drop empty", 64'(out_v), 64'd0);
    store = 1'b1; core_result = mkvec('h300); acc++;
    tick();
    store = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("restart out_d", out_d, 64'('h300 + k));
      tick();
    end
    chk("restart idle", 64'(out_v), 64'd0);

    // Two stores then last: 32 data beats then the terminator
    store = 1'b1; core_result = mkvec('h400); acc++;
    tick();
    for (int n = 0; n < 32; n++) begin
      store = (n == 0); last = (n == 1); core_result = mkvec('h410);
      if (n == 0) acc++;
      chk("term data out_d", out_d, 64'('h400 + n));
      chk("term data out_last", 64'(out_last), 64'd0);
      tick();
    end
    store = 1'b0; last = 1'b0;
    chk("term out_v", 64'(out_v), 64'd1);
    chk("term out_d", out_d, 64'd0);
    chk("term out_last", 64'(out_last), 64'd1);
    tick();
    chk("term idle", 64'(out_v), 64'd0);

    // Reset while sending with a full FIFO and a pending terminator
    out_r = 1'b0;
    for (int j = 0; j < 4; j++) begin
      store = 1'b1; last = (j == 3); core_result = mkvec('h500 + j * 16);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; store = 1'b0; last = 1'b0; acc = 0;
    chk("rst out_v", 64'(out_v), 64'd0);
    chk("rst out_d", out_d, 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    chk("rst vec_count", 64'(vec_count), 64'(expcnt(0)));
    tick();
    chk("rst stays idle", 64'(out_v), 64'd0);

    // Store into a full FIFO on the pop cycle is accepted
    for (int j = 0; j < 4; j++) begin
      store = 1'b1; core_result = mkvec(j * 16); acc++;
      tick();
    end
    store = 1'b0; out_r = 1'b1;
    for (int n = 0; n < 80; n++) begin
      store = (n == 15); core_result = mkvec(64);
      if (n == 15) acc++;
      chk("fullpop out_v", 64'(out_v), 64'd1);
      chk("fullpop out_d", out_d, 64'(n));
      tick();
    end
    store = 1'b0;
    chk("fullpop idle", 64'(out_v), 64'd0);
    chk("fullpop overflow", 64'(overflow), 64'd0);
    chk("fullpop vec_count", 64'(vec_count), 64'(expcnt(acc)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/result_box.md
RESULT_BOX -- requirements
Module: result_box

Interface
REQ-001 Parameter DIM, default 1023: hypervector MSB index; vector width is DIM+1.
REQ-002 Parameter OUT_W, default 64: output beat width; (DIM+1) SHALL be a multiple of OUT_W; BEATS = (DIM+1)/OUT_W.
REQ-003 Parameter DEPTH, default 4: vector FIFO entries, power of two, >=2.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 run  in  1  accelerator active; low = soft clear.
REQ-007 store  in  1  core result valid pulse.
REQ-008 core_result  in  DIM+1  core result vector, sampled when store=1.
REQ-009 last  in  1  core end-of-program pulse.
REQ-010 out_d  out  OUT_W  output beat data.
REQ-011 out_v  out  1  output beat valid.
REQ-012 out_r  in  1  downstream ready; a beat transfers when out_v & out_r.
REQ-013 out_last  out  1  marks the terminator beat.
REQ-014 overflow  out  1  sticky: a store was dropped.
REQ-015 vec_count  out  32  accepted-vector count (see Configuration).

Function
REQ-016 Each store=1 cycle SHALL push core_result into the FIFO; there is no backpressure toward the core.
REQ-017 If store=1 while the FIFO is full and no pop occurs that cycle, the vector SHALL be dropped and overflow SHALL be set to 1.
REQ-018 If the FIFO is full and a pop occurs in the same cycle as store, the push SHALL succeed with no overflow.
REQ-019 FSM states: IDLE, SEND, TERM.
REQ-020 In IDLE with the FIFO non-empty: go to SEND with beat index 0. In IDLE with the FIFO empty and last_pend=1: go to TERM.
REQ-021 In SEND, out_v=1 and out_d = head[k*OUT_W +: OUT_W] for beat index k, LSB beat first.
- k advances only on transfer.
- On transfer of beat BEATS-1: pop the head, reset k to 0.
- Then stay in SEND if another entry is present; else go to TERM if last_pend=1; else go to IDLE.
REQ-022 Latency: store at cycle t into an empty FIFO with the FSM in IDLE SHALL give out_v=1 with beat 0 at cycle t+1.
REQ-023 last=1 SHALL set last_pend.
REQ-024 TERM: out_v=1, out_d=0, out_last=1. On transfer, clear last_pend and go to IDLE; out_last is 0 in all other states.
REQ-025 store and last in the same cycle: the vector is pushed, and the terminator follows it.
REQ-026 out_d and out_last SHALL hold stable while out_v=1 and out_r=0.
REQ-027 run=0 for any cycle: flush the FIFO, clear k and last_pend, FSM to IDLE, out_v=0 next cycle; overflow and vec_count are retained.
- Mid-beat abort is permitted here.

Reset
REQ-028 On rst=1 at posedge:
- FSM=IDLE, FIFO empty, k=0, last_pend=0.
- out_v=0, out_d=0, out_last=0, overflow=0, vec_count=0.
- rst overrides run, store and last.

Configuration
REQ-029 Macro RESULT_BOX_STATS_EN defined: vec_count increments by 1 per accepted push (not dropped ones) and wraps at 2^32.
REQ-030 Macro RESULT_BOX_STATS_EN undefined: the vec_count port remains and is tied to 0, with no counter logic.

Structure
REQ-031 Shared package hdc_pkg holds:
- DIM and OUT_W defaults;
- the BEATS derivation function;
- the box_state_t enum {IDLE, SEND, TERM}.
REQ-032 Sub-module vec_fifo:
- parameterised width/depth, synchronous, first-word-fall-through;
- outputs full/empty;
- instantiated once; the FSM and serializer stay in result_box.

Verification
REQ-033 Single vector: store with core_result = {16 words i = 0..15, word i = i}, out_r=1 -> beats 0..15 emitted on consecutive cycles starting t+1, out_d = 0,1,..,15.
REQ-034 Backpressure: out_r toggling 1,0,1,0 during a vector -> every beat appears exactly once, and out_d is stable while out_r=0.
REQ-035 Overflow: DEPTH=4, out_r=0, six stores -> overflow=1, vec_count=4; after out_r=1, exactly 64 beats then idle.
REQ-036 Terminator: two stores then last, out_r=1 -> 32 data beats, then one beat with out_d=0 and out_last=1; last with an empty FIFO -> the terminator alone at t+2.
REQ-037 run drop: run=0 during beat 5 -> out_v=0 next cycle, FIFO empty, overflow unchanged; a later store restarts at beat 0.
REQ-038 rst asserted while in SEND with a full FIFO -> all outputs match REQ-028 on the next cycle.
